// File: rtl/image_processor_array_pkg.sv
// Shared opcode/pixel types for the cell processors and the lane array top.
package CellProcessingPkg;
    localparam int CP_PIXEL_W  = 8;
    localparam int CP_OPCODE_W = 4;
    localparam logic [CP_PIXEL_W-1:0] PIXEL_MAX = '1;

    typedef logic [CP_PIXEL_W-1:0] pixel_t;

    typedef enum logic [CP_OPCODE_W-1:0] {
        PASS_A     = 4'd0,
        ADD_SAT    = 4'd1,
        SUB_SAT    = 4'd2,
        AVG        = 4'd3,
        MAX        = 4'd4,
        MIN        = 4'd5,
        THRESH     = 4'd6,
        INVERT     = 4'd7,
        OFFSET_SAT = 4'd8,
        BLEND      = 4'd9
    } opcode_t;
endpackage

package ImageProcessingPkg;
    import CellProcessingPkg::*;

    localparam int IP_NUM_LANES = 4;

    typedef pixel_t [IP_NUM_LANES-1:0] lane_vec_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } ipa_state_t;
endpackage

// File: rtl/image_processor_array_cell.sv
// One lane: combinational pixel ALU followed by CELL_LATENCY result registers.
module cell_processor
    import CellProcessingPkg::*;
#(
    parameter int PIXEL_W      = CP_PIXEL_W,
    parameter int CELL_LATENCY = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  opcode_t            opcode,
    input  logic [PIXEL_W-1:0] userVal,
    input  logic [PIXEL_W-1:0] pixelA,
    input  logic [PIXEL_W-1:0] pixelB,
    output logic [PIXEL_W-1:0] result
);
    localparam int AW = 2*PIXEL_W + 1;
    localparam logic [PIXEL_W-1:0] MAX_VAL = '1;

    logic [PIXEL_W:0]   sumAB;
    logic [PIXEL_W:0]   sumAU;
    logic [AW-1:0]      blendAcc;
    logic [PIXEL_W-1:0] aluOut;
    logic [PIXEL_W-1:0] stage [CELL_LATENCY];

    assign sumAB    = (PIXEL_W+1)'(pixelA) + (PIXEL_W+1)'(pixelB);
    assign sumAU    = (PIXEL_W+1)'(pixelA) + (PIXEL_W+1)'(userVal);
    // Divide by 2^PIXEL_W instead of MAX_VAL; result may be one LSB low.
    assign blendAcc = AW'(pixelA) * AW'(userVal) + AW'(pixelB) * AW'(MAX_VAL - userVal);

    always_comb begin
        aluOut = pixelA;
        case (opcode)
            ADD_SAT:    aluOut = sumAB[PIXEL_W] ? MAX_VAL : sumAB[PIXEL_W-1:0];
            SUB_SAT:    aluOut = (pixelA > pixelB) ? (pixelA - pixelB) : '0;
            AVG:        aluOut = PIXEL_W'(sumAB >> 1);
            MAX:        aluOut = (pixelA >= pixelB) ? pixelA : pixelB;
            MIN:        aluOut = (pixelA <= pixelB) ? pixelA : pixelB;
            THRESH:     aluOut = (pixelA >= userVal) ? MAX_VAL : '0;
            INVERT:     aluOut = MAX_VAL - pixelA;
            OFFSET_SAT: aluOut = sumAU[PIXEL_W] ? MAX_VAL : sumAU[PIXEL_W-1:0];
            BLEND:      aluOut = PIXEL_W'(blendAcc >> PIXEL_W);
            default:    aluOut = pixelA;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < CELL_LATENCY; i++) stage[i] <= '0;
        end else begin
            stage[0] <= aluOut;
            for (int i = 1; i < CELL_LATENCY; i++) stage[i] <= stage[i-1];
        end
    end

    assign result = stage[CELL_LATENCY-1];
endmodule

// File: rtl/image_processor_array.sv
// NUM_LANES cell processors sharing one latched opcode, feeding a credit-managed output FIFO.
//   state | meaning
//   IDLE  | no opcode loaded, beats refused
//   RUN   | accepting beats under the latched opcode
//   DRAIN | new opcode pending, waiting for pipeline and FIFO to empty
module image_processor_array
    import CellProcessingPkg::*;
    import ImageProcessingPkg::*;
#(
    parameter int PIXEL_W      = CP_PIXEL_W,
    parameter int NUM_LANES    = IP_NUM_LANES,
    parameter int OPCODE_W     = CP_OPCODE_W,
    parameter int CELL_LATENCY = 2,
    parameter int OUT_DEPTH    = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         op_load,
    input  logic [OPCODE_W-1:0]          opcode,
    input  logic [PIXEL_W-1:0]           user_input,
    output logic                         op_ack,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NUM_LANES*PIXEL_W-1:0] in_pixelA,
    input  logic [NUM_LANES*PIXEL_W-1:0] in_pixelB,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NUM_LANES*PIXEL_W-1:0] out_pixel,
    output logic                         busy
);
    localparam int LW    = NUM_LANES * PIXEL_W;
    localparam int PTR_W = $clog2(OUT_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    ipa_state_t         state, nextState;
    opcode_t            opCodeReg, pendOp;
    logic [PIXEL_W-1:0] userReg, pendUser;
    logic               opAck;
    logic               latchOp, capturePend;

    logic [CELL_LATENCY-1:0] validPipe;
    logic [CNT_W-1:0]        inflight;
    logic [CNT_W-1:0]        fifoCount;
    logic [PTR_W-1:0]        wrPtr, rdPtr;
    logic [LW-1:0]           fifoMem [OUT_DEPTH];
    logic [LW-1:0]           cellOut;
    logic                    accept, push, pop, fifoValid;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < CELL_LATENCY; i++) inflight = inflight + CNT_W'(validPipe[i]);
    end

    // Credits exclude this cycle's pop, so the FIFO can never overflow.
    assign in_ready  = (state == RUN) && ((fifoCount + inflight) < CNT_W'(OUT_DEPTH));
    assign accept    = in_valid && in_ready;
    assign fifoValid = (fifoCount != '0);
    assign push      = validPipe[CELL_LATENCY-1];
    assign pop       = fifoValid && out_ready;

    always_comb begin
        nextState   = state;
        latchOp     = 1'b0;
        capturePend = 1'b0;
        case (state)
            IDLE: begin
                if (op_load) begin
                    nextState = RUN;
                    latchOp   = 1'b1;
                end
            end
            RUN: begin
                if (op_load) begin
                    nextState   = DRAIN;
                    capturePend = 1'b1;
                end
            end
            DRAIN: begin
                if (inflight == '0 && fifoCount == '0) begin
                    nextState = RUN;
                    latchOp   = 1'b1;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            opAck     <= 1'b0;
            opCodeReg <= PASS_A;
            userReg   <= '0;
            pendOp    <= PASS_A;
            pendUser  <= '0;
        end else begin
            state <= nextState;
            opAck <= latchOp;
            if (capturePend) begin
                pendOp   <= opcode_t'(opcode);
                pendUser <= user_input;
            end
            if (latchOp) begin
                opCodeReg <= (state == DRAIN) ? pendOp : opcode_t'(opcode);
                userReg   <= (state == DRAIN) ? pendUser : user_input;
            end
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : gLane
        cell_processor #(
            .PIXEL_W      (PIXEL_W),
            .CELL_LATENCY (CELL_LATENCY)
        ) uCell (
            .clk     (clk),
            .rst     (rst),
            .opcode  (opCodeReg),
            .userVal (userReg),
            .pixelA  (in_pixelA[g*PIXEL_W +: PIXEL_W]),
            .pixelB  (in_pixelB[g*PIXEL_W +: PIXEL_W]),
            .result  (cellOut[g*PIXEL_W +: PIXEL_W])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            validPipe <= '0;
            wrPtr     <= '0;
            rdPtr     <= '0;
            fifoCount <= '0;
        end else begin
            validPipe[0] <= accept;
            for (int i = 1; i < CELL_LATENCY; i++) validPipe[i] <= validPipe[i-1];
            if (push) wrPtr <= wrPtr + PTR_W'(1);
            if (pop)  rdPtr <= rdPtr + PTR_W'(1);
            if (push && !pop)      fifoCount <= fifoCount + CNT_W'(1);
            else if (pop && !push) fifoCount <= fifoCount - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifoMem[wrPtr] <= cellOut;
    end

    assign out_valid = fifoValid;
    assign out_pixel = fifoValid ? fifoMem[rdPtr] : '0;
    assign op_ack    = opAck;
    assign busy      = (state != IDLE);
endmodule

// File: tb/tb_image_processor_array.sv
// Directed vector bench for image_processor_array with default parameters.
module tb_image_processor_array;
    logic        clk;
    logic        rst;
    logic        op_load;
    logic [3:0]  opcode;
    logic [7:0]  user_input;
    logic        op_ack;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pixelA;
    logic [31:0] in_pixelB;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pixel;
    logic        busy;

    int totalCnt = 0;
    int passCnt  = 0;

    image_processor_array dut (
        .clk        (clk),
        .rst        (rst),
        .op_load    (op_load),
        .opcode     (opcode),
        .user_input (user_input),
        .op_ack     (op_ack),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pixelA  (in_pixelA),
        .in_pixelB  (in_pixelB),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pixel  (out_pixel),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [7:0]  user;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];

    function automatic logic [31:0] pack4(input logic [7:0] l0, input logic [7:0] l1,
                                          input logic [7:0] l2, input logic [7:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    function automatic logic [31:0] splat(input logic [7:0] v);
        return {v, v, v, v};
    endfunction

    function automatic logic [31:0] beatWord(input int k);
        logic [7:0] v;
        v = 8'(k);
        return pack4(v, v + 8'd16, v + 8'd32, v + 8'd48);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic loadOp(input logic [3:0] op, input logic [7:0] usr);
        bit seen;
        seen = 1'b0;
        opcode = op;
        user_input = usr;
        op_load = 1'b1;
        tick();
        op_load = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (op_ack) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check("op_ack_seen", 32'(seen), 32'd1);
        tick();
        check("op_ack_single", 32'(op_ack), 32'd0);
    endtask

    task automatic sendAndCheck(input string name, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] exp);
        bit accepted;
        bit seen;
        accepted = 1'b0;
        seen = 1'b0;
        in_pixelA = a;
        in_pixelB = b;
        in_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (in_ready) begin
                accepted = 1'b1;
                tick();
                break;
            end
            tick();
        end
        in_valid = 1'b0;
        check({name, "_accept"}, 32'(accepted), 32'd1);
        for (int c = 0; c < 20; c++) begin
            if (out_valid) begin
                seen = 1'b1;
                check(name, out_pixel, exp);
                tick();
                break;
            end
            tick();
        end
        check({name, "_out_seen"}, 32'(seen), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent, got, acc, pops, bad, gotAtAck;
        bit leak, stale, ackSeen, loadIssued;

        vecs[0]  = '{4'd1, 8'd0,   pack4(10, 200, 255, 0), pack4(5, 100, 1, 0),   pack4(15, 255, 255, 0)};
        vecs[1]  = '{4'd6, 8'd128, pack4(127, 128, 0, 255), 32'h0,                pack4(0, 255, 0, 255)};
        vecs[2]  = '{4'd2, 8'd0,   pack4(10, 5, 255, 100), pack4(3, 9, 255, 0),   pack4(7, 0, 0, 100)};
        vecs[3]  = '{4'd3, 8'd0,   pack4(255, 3, 100, 0),  pack4(255, 4, 50, 1),  pack4(255, 3, 75, 0)};
        vecs[4]  = '{4'd4, 8'd0,   pack4(1, 200, 7, 0),    pack4(2, 100, 7, 255), pack4(2, 200, 7, 255)};
        vecs[5]  = '{4'd5, 8'd0,   pack4(1, 200, 7, 0),    pack4(2, 100, 7, 255), pack4(1, 100, 7, 0)};
        vecs[6]  = '{4'd7, 8'd0,   pack4(0, 255, 15, 100), 32'h0,                 pack4(255, 0, 240, 155)};
        vecs[7]  = '{4'd8, 8'd100, pack4(0, 155, 156, 255), 32'h0,                pack4(100, 255, 255, 255)};
        vecs[8]  = '{4'd9, 8'd128, pack4(255, 0, 100, 200), pack4(0, 255, 50, 200), pack4(127, 126, 74, 199)};
        vecs[9]  = '{4'd9, 8'd0,   pack4(1, 2, 3, 4),      pack4(255, 0, 128, 10), pack4(254, 0, 127, 9)};
        vecs[10] = '{4'd0, 8'd0,   pack4(1, 2, 3, 4),      splat(9),              pack4(1, 2, 3, 4)};
        vecs[11] = '{4'd12, 8'd0,  pack4(9, 8, 7, 6),      splat(1),              pack4(9, 8, 7, 6)};

        rst = 1'b0;
        op_load = 1'b0;
        opcode = '0;
        user_input = '0;
        in_valid = 1'b0;
        in_pixelA = '0;
        in_pixelB = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_op_ack", 32'(op_ack), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_pixel", out_pixel, 32'd0);

        // IDLE must refuse beats.
        rst = 1'b1;
        in_valid = 1'b1;
        in_pixelA = splat(8'h55);
        leak = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (in_ready) leak = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        check("idle_in_ready", 32'(leak), 32'd0);
        check("idle_out_valid", 32'(out_valid), 32'd0);

        // First opcode from IDLE and exact pipeline latency.
        loadOp(4'd1, 8'd0);
        check("run_busy", 32'(busy), 32'd1);
        check("run_in_ready", 32'(in_ready), 32'd1);
        in_pixelA = pack4(10, 200, 255, 0);
        in_pixelB = pack4(5, 100, 1, 0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("lat_cycle1_valid", 32'(out_valid), 32'd0);
        tick();
        check("lat_cycle2_valid", 32'(out_valid), 32'd0);
        tick();
        check("lat_cycle3_valid", 32'(out_valid), 32'd1);
        check("lat_cycle3_pixel", out_pixel, pack4(15, 255, 255, 0));
        tick();

        for (int i = 0; i < 12; i++) begin
            loadOp(vecs[i].op, vecs[i].user);
            sendAndCheck($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp);
        end

        // Back-pressure: 12 beats into a stalled output.
        loadOp(4'd0, 8'd0);
        out_ready = 1'b0;
        sent = 0;
        for (int c = 0; c < 30; c++) begin
            in_valid = (sent < 12);
            in_pixelA = beatWord(sent + 1);
            if (in_valid && in_ready) sent++;
            tick();
        end
        check("bp_accepted_before_stall", 32'(sent), 32'd8);
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 100 && got < 12; c++) begin
            in_valid = (sent < 12);
            in_pixelA = beatWord(sent + 1);
            if (in_valid && in_ready) sent++;
            if (out_valid) begin
                check($sformatf("bp_beat%0d", got + 1), out_pixel, beatWord(got + 1));
                got++;
            end
            tick();
        end
        in_valid = 1'b0;
        check("bp_received", 32'(got), 32'd12);
        repeat (10) tick();
        check("bp_no_duplicate", 32'(out_valid), 32'd0);

        // Opcode change mid-stream waits for the old beats to leave.
        sent = 0;
        got = 0;
        gotAtAck = -1;
        leak = 1'b0;
        ackSeen = 1'b0;
        loadIssued = 1'b0;
        opcode = 4'd7;
        user_input = 8'd0;
        for (int c = 0; c < 40 && !ackSeen; c++) begin
            if (loadIssued && in_ready) leak = 1'b1;
            in_valid = (sent < 3);
            in_pixelA = splat(8'h11 * 8'(sent + 1));
            op_load = (sent == 3) && !loadIssued;
            if (in_valid && in_ready) sent++;
            if (op_load) loadIssued = 1'b1;
            if (out_valid) begin
                check($sformatf("chg_old%0d", got + 1), out_pixel, splat(8'h11 * 8'(got + 1)));
                got++;
            end
            tick();
            if (op_ack) begin
                ackSeen = 1'b1;
                gotAtAck = got;
            end
        end
        op_load = 1'b0;
        in_valid = 1'b0;
        check("chg_ack_seen", 32'(ackSeen), 32'd1);
        check("chg_ready_during_drain", 32'(leak), 32'd0);
        check("chg_outputs_before_ack", 32'(gotAtAck), 32'd3);
        sendAndCheck("chg_invert", splat(8'h0F), 32'h0, splat(8'hF0));

        // Full FIFO with out_ready high: one beat in and out every cycle.
        out_ready = 1'b0;
        in_pixelA = splat(8'h00);
        in_valid = 1'b1;
        repeat (20) tick();
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_out_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        acc = 0;
        pops = 0;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            if (c >= 4) begin
                if (in_ready) acc++;
                if (out_valid) pops++;
            end
            if (out_valid && out_pixel != splat(8'hFF)) bad++;
            tick();
        end
        in_valid = 1'b0;
        check("tput_accepts", 32'(acc), 32'd16);
        check("tput_pops", 32'(pops), 32'd16);
        check("tput_data", 32'(bad), 32'd0);
        repeat (30) tick();
        check("tput_drained", 32'(out_valid), 32'd0);

        // Reset with five beats in flight.
        out_ready = 1'b0;
        sent = 0;
        for (int c = 0; c < 20 && sent < 5; c++) begin
            in_valid = 1'b1;
            in_pixelA = beatWord(sent + 100);
            if (in_ready) sent++;
            tick();
        end
        in_valid = 1'b0;
        check("mid_rst_sent", 32'(sent), 32'd5);
        rst = 1'b0;
        #1;
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_op_ack", 32'(op_ack), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_out_pixel", out_pixel, 32'd0);
        tick();
        tick();
        rst = 1'b1;
        out_ready = 1'b1;
        in_valid = 1'b1;
        leak = 1'b0;
        stale = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (in_ready) leak = 1'b1;
            if (out_valid) stale = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        check("post_rst_in_ready", 32'(leak), 32'd0);
        check("post_rst_stale", 32'(stale), 32'd0);
        loadOp(4'd1, 8'd0);
        sendAndCheck("post_rst_add", pack4(1, 2, 3, 4), pack4(1, 1, 1, 1), pack4(2, 3, 4, 5));

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end
endmodule

// File: doc/image_processor_array.md
Name: image_processor_array

Overview:
- Parametrised successor to the single-pair image processor top.
- Accepts NUM_LANES pixel pairs per beat over a valid/ready stream and applies one latched opcode plus a user operand across NUM_LANES parallel cell processors.
- Results pass through a fixed-latency pipeline into an output FIFO, so downstream back-pressure never stalls the cell pipeline.
- Sits between the frame fetch/DMA front end and the writeback stage.

Parameters:
- PIXEL_W, 8, bits per pixel channel.
- NUM_LANES, 4, parallel cell processors (pixels per beat).
- OPCODE_W, 4, opcode width.
- CELL_LATENCY, 2, pipeline stages through a cell (>=1).
- OUT_DEPTH, 8, output FIFO entries (power of 2, >= CELL_LATENCY+1).

Ports:
- clk, in, 1, system clock.
- rst, in, 1, asynchronous active-low reset.
- op_load, in, 1, request to latch opcode and user_input.
- opcode, in, OPCODE_W, operation select.
- user_input, in, PIXEL_W, scalar operand for threshold/offset ops.
- op_ack, out, 1, one-cycle pulse when the opcode is latched.
- in_valid, in, 1, input beat valid.
- in_ready, out, 1, block accepts a beat.
- in_pixelA, in, NUM_LANES*PIXEL_W, lane i at bits [i*PIXEL_W +: PIXEL_W].
- in_pixelB, in, NUM_LANES*PIXEL_W, second operand per lane.
- out_valid, out, 1, FIFO head valid.
- out_ready, in, 1, downstream accepts.
- out_pixel, out, NUM_LANES*PIXEL_W, processed beat.
- busy, out, 1, high when state != IDLE.

Behaviour:
- Reset (rst=0, async): state=IDLE; opCodeReg=0 (PASS_A); userReg=0; pipeline valid bits=0; FIFO empty.
  - Outputs at reset: in_ready=0, out_valid=0, op_ack=0, busy=0, out_pixel=0.
  - Reset mid-operation discards all in-flight and buffered beats.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE:
    - op_load=1 -> latch opcode/user_input, op_ack=1 next cycle, go to RUN.
    - in_ready=0 in IDLE (no beats accepted before an opcode is loaded).
  - RUN:
    - in_ready = (fifo_count + inflight) < OUT_DEPTH, where inflight = number of set pipeline valid bits.
    - Accept when in_valid && in_ready.
    - op_load=1 in RUN -> go to DRAIN; opcode is not latched yet and in_ready=0 from the next cycle.
  - DRAIN:
    - Wait until inflight==0 and FIFO empty, then latch the pending opcode/user_input (captured at entry to DRAIN), pulse op_ack, return to RUN.
    - A new opcode therefore never mixes with beats of the old opcode.
- Pipeline: an accepted beat appears in the FIFO exactly CELL_LATENCY cycles after acceptance. out_valid asserts the cycle after FIFO write (latency CELL_LATENCY+1 in to out when the FIFO is empty).
- Credit rule guarantees the FIFO never overflows, so the pipeline has no stall path.
- FIFO:
  - Simultaneous push and pop when full or empty is legal; count unchanged when both occur.
  - Pointers wrap modulo OUT_DEPTH.
  - out_pixel holds the head entry; it is stable while out_valid && !out_ready.
- Cell ops (unsigned, per lane, all results PIXEL_W wide, max = 2^PIXEL_W-1):
  - 0 PASS_A: A.
  - 1 ADD_SAT: min(A+B, max), computed at PIXEL_W+1 bits.
  - 2 SUB_SAT: A>B ? A-B : 0.
  - 3 AVG: (A+B)>>1, PIXEL_W+1-bit sum, truncating.
  - 4 MAX: max(A, B).
  - 5 MIN: min(A, B).
  - 6 THRESH: A>=user ? max : 0.
  - 7 INVERT: max-A.
  - 8 OFFSET_SAT: min(A+user, max).
  - 9 BLEND: (A*user + B*(max-user))/max, approximated as >>PIXEL_W with a 2*PIXEL_W+1-bit accumulate.
  - Other codes: PASS_A.
- busy deasserts only in IDLE; RUN returns to IDLE never. Only reset exits RUN/DRAIN to IDLE.

Decomposition:
- CellProcessingPkg:
  - opcode enum (opcode_t, OPCODE_W bits) with the values above.
  - pixel_t as logic [PIXEL_W-1:0].
  - localparam PIXEL_MAX.
- ImageProcessingPkg: lane_vec_t (NUM_LANES x pixel_t), ipa_state_t enum {IDLE, RUN, DRAIN}.
- Sub-module cell_processor:
  - One lane: pipelined ALU with CELL_LATENCY registers and an async active-low reset.
  - Instantiated NUM_LANES times via generate.
- FIFO and FSM stay inline in the top.

Test Plan (defaults: PIXEL_W=8, NUM_LANES=4, CELL_LATENCY=2, OUT_DEPTH=8):
- Reset then op_load opcode=1 (ADD_SAT): lanes A={10,200,255,0}, B={5,100,1,0}.
  - op_ack pulses once.
  - out_pixel={15,255,255,0} with out_valid at cycle 3 after acceptance.
- THRESH with user=128, A={127,128,0,255} -> out_pixel={0,255,0,255}.
- Back-pressure: out_ready=0, stream 12 beats continuously.
  - in_ready drops after exactly 8 accepted beats.
  - Release out_ready; all 12 beats emerge in order with no loss or duplication.
- Opcode change mid-stream: 3 beats under PASS_A, then op_load opcode=7 (INVERT) with out_ready=1.
  - in_ready=0 until the drain completes.
  - op_ack follows the last old output.
  - Next beat A=0x0F -> 0xF0.
- Simultaneous push/pop at full FIFO with out_ready=1 and continuous in_valid: sustained throughput of 1 beat/cycle, count constant.
- Assert rst low mid-stream with 5 beats in flight: outputs return to reset values immediately. After release, in_ready=0 until a new op_load; no stale beats appear.
